clause_scan_eval: RTL
=====================

Name: clause_scan_eval

Overview:
- Sequencer and evaluator that sits directly after the clause table memory.
- On `start`, it latches the current variable assignment and issues back-to-back row reads to the clause table.
- Each returned 480-bit row holds 20 clause slots; the block evaluates every slot against the assignment and accumulates the unsatisfied-clause count.
- It reports the first unsatisfied clause, which the WalkSAT flip-selection logic uses to pick the next clause to repair.

Parameters:
- ADDR_W, 11, clause table address width (2048 rows).
- SLOTS, 20, clause slots per row.
- CLAUSE_W, 24, bits per slot: three 8-bit literals.
- VAR_N, 128, number of variables; literal index field is 7 bits.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to scan; honoured only when idle.
- num_rows  in  12  rows to scan, 0..2048; values >2048 clamp to 2048.
- assign_in  in  128  variable assignment; bit i = value of variable i.
- ct_read  out  1  read enable to clause table.
- ct_address  out  11  row address to clause table.
- ct_row  in  480  clause table q; slot 1 = [479:456] … slot 20 = [23:0].
- busy  out  1  high from the cycle after `start` is accepted until `done`.
- done  out  1  one-cycle pulse; results valid in that cycle and held until the next accepted `start`.
- unsat_count  out  16  number of unsatisfied non-empty clauses (max 40960, no overflow).
- any_unsat  out  1  unsat_count != 0.
- first_addr  out  11  row of the first unsatisfied clause.
- first_slot  out  5  slot (1..20) of the first unsatisfied clause; 0 if none.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, internal pipeline valids cleared.
- Reset mid-scan aborts immediately: no further reads, no `done`.
- Literal encoding: bit 7 = negate, bits 6:0 = variable index. Index 0 is reserved meaning "absent literal", which evaluates false.
  - Literal true = assign[idx] XOR negate, for idx != 0.
- A clause word of all zeros is an empty slot: it is never counted and never reported.
- A clause is unsatisfied when it is non-empty and none of its three literals is true.
  - A non-empty clause whose literals are all absent (e.g. 0x800000) counts as unsatisfied.
- `assign_in` and the clamped `num_rows` are latched in the cycle `start` is accepted. Later changes have no effect on the running scan.
- `start` while busy is ignored; there is no queueing.
- FSM states:
  - IDLE: on `start`, go to SCAN; or to DRAIN if num_rows = 0.
  - SCAN: issue one read per cycle, addresses 0..N-1; after issuing N-1, go to DRAIN.
  - DRAIN: wait for the pipeline to empty, pulse `done`, return to IDLE.
- Timing, with cycle 0 = cycle `start` is sampled high in IDLE:
  - Row k: ct_read=1, ct_address=k in cycle 1+k.
  - ct_row for that row is valid in cycle 2+k (one-cycle registered RAM latency).
  - Stage 1 registers the 20 per-slot unsat bits plus row address; visible in cycle 3+k.
  - Stage 2 adds popcount(unsat bits) into the accumulator and updates first-unsat.
  - `done` is high in cycle N+3; busy is high in cycles 1..N+2.
  - ct_read is 0 in every other cycle; ct_address holds its last value.
- num_rows = 0: no reads are issued; `done` pulses in cycle 3 with unsat_count=0, any_unsat=0, first_addr=0, first_slot=0.
- First-unsat ordering: lowest row address wins; within a row, lowest slot number wins. It is captured once per scan and never overwritten by later rows.
- Accumulator, first-unsat registers and any_unsat are cleared on `start` acceptance. They are visible only at `done`; intermediate values are undefined to consumers.

Test Plan:
- **Single-row mixes:** N=1, row 0 = slot1 0x010203, all other slots 0, assign=0 → reads addr 0 in cycle 1 only; done in cycle 4; count=1, first=(0,1). Repeat with assign bit 2 set → count=0, first_slot=0, any_unsat=0.
- **Negated literal and empty slots:** slot5 = 0x85_00_00, assign bit 5 = 0 → satisfied. Remaining slots 0 → ignored; count=0.
- **Full table:** N=2048, every slot = 0x010000, assign=0 → 2048 consecutive reads; done in cycle 2051; count=40960; first=(0,1).
- **First-unsat ordering with changing inputs:** N=8; unsat clauses only at row 5 slots 7 and 3, and row 6 slot 1 → count=3, first=(5,3). Change assign_in during the scan → results unchanged.
- **Edge conditions:**
  - num_rows=0 → no ct_read; done in cycle 3; all results 0.
  - num_rows=4000 → clamped, 2048 reads.
  - Second `start` during busy → ignored, single done.
- **Reset mid-scan:** drop rst_n during cycle 10 of a 100-row scan → outputs 0 asynchronously, no done. A new `start` after release runs a full, correct scan.

Source files
------------

// File: rtl/clause_scan_eval.sv
// Clause table scan sequencer and evaluator.
// Streams rows 0..N-1 out of the clause table, checks every clause slot
// against a latched variable assignment, counts unsatisfied clauses and
// remembers the first unsatisfied one (lowest row, then lowest slot).
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start; results from the last scan are held
// S_SCAN  | one clause table read per cycle, addresses 0..N-1
// S_DRAIN | read/eval pipeline emptying; done pulses on the way out
module clause_scan_eval #(
    parameter int ADDR_W   = 11,
    parameter int SLOTS    = 20,
    parameter int CLAUSE_W = 24,
    parameter int VAR_N    = 128
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [ADDR_W:0]           num_rows,
    input  logic [VAR_N-1:0]          assign_in,
    output logic                      ct_read,
    output logic [ADDR_W-1:0]         ct_address,
    input  logic [SLOTS*CLAUSE_W-1:0] ct_row,
    output logic                      busy,
    output logic                      done,
    output logic [15:0]               unsat_count,
    output logic                      any_unsat,
    output logic [ADDR_W-1:0]         first_addr,
    output logic [4:0]                first_slot
);

    localparam int               ROW_W      = SLOTS * CLAUSE_W;
    localparam logic [ADDR_W:0]  MAX_ROWS   = (ADDR_W + 1)'(1) << ADDR_W;
    // Cycles spent in S_DRAIN before done: covers the RAM + stage-1 + stage-2 latency.
    localparam logic [1:0]       DRAIN_WAIT = 2'd1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                start_ok;
    logic [ADDR_W:0]     rows_clamped;
    logic                rows_zero;
    logic                at_last;

    logic [VAR_N-1:0]    assign_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   last_addr_q;
    logic [1:0]          drain_cnt_q;
    logic                done_q;

    logic                rd_v_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [SLOTS-1:0]    row_unsat;
    logic                s1_v_q;
    logic [SLOTS-1:0]    s1_bits_q;
    logic [ADDR_W-1:0]   s1_addr_q;

    logic [15:0]         count_q;
    logic [ADDR_W-1:0]   first_addr_q;
    logic [4:0]          first_slot_q;

    // Literal: bit 7 negates, bits 6:0 index a variable; index 0 is an absent literal.
    function automatic logic lit_true(input logic [7:0] lit, input logic [VAR_N-1:0] a);
        logic [6:0] idx;
        idx = lit[6:0];
        return (idx != 7'd0) && (a[idx] ^ lit[7]);
    endfunction

    function automatic logic [4:0] popcount(input logic [SLOTS-1:0] bits);
        logic [4:0] sum;
        sum = 5'd0;
        for (int j = 0; j < SLOTS; j++) begin
            sum = sum + 5'(bits[j]);
        end
        return sum;
    endfunction

    // bit 0 is slot 1, so the lowest set bit is the lowest slot number
    function automatic logic [4:0] lowest_slot(input logic [SLOTS-1:0] bits);
        logic [4:0] slot;
        slot = 5'd0;
        for (int j = SLOTS - 1; j >= 0; j--) begin
            if (bits[j]) begin
                slot = 5'(j + 1);
            end
        end
        return slot;
    endfunction

    assign start_ok     = start && (state_q == S_IDLE);
    assign rows_clamped = (num_rows > MAX_ROWS) ? MAX_ROWS : num_rows;
    assign rows_zero    = (rows_clamped == '0);
    assign at_last      = (addr_q == last_addr_q);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and FSM-derived outputs.
    always_comb begin
        state_d = state_q;
        ct_read = 1'b0;
        busy    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = rows_zero ? S_DRAIN : S_SCAN;
                end
            end
            S_SCAN: begin
                ct_read = 1'b1;
                busy    = 1'b1;
                if (at_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (drain_cnt_q == 2'd0) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Scan control: latch job parameters, step the read address, drain timer and done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            assign_q    <= '0;
            addr_q      <= '0;
            last_addr_q <= '0;
            drain_cnt_q <= DRAIN_WAIT;
            done_q      <= 1'b0;
        end else begin
            if (start_ok) begin
                assign_q    <= assign_in;
                addr_q      <= '0;
                // a full 2048-row table wraps to 2047 here, which is the intended last row
                last_addr_q <= rows_clamped[ADDR_W-1:0] - ADDR_W'(1);
            end else if ((state_q == S_SCAN) && !at_last) begin
                addr_q <= addr_q + ADDR_W'(1);
            end

            if (state_q != S_DRAIN) begin
                drain_cnt_q <= DRAIN_WAIT;
            end else if (drain_cnt_q != 2'd0) begin
                drain_cnt_q <= drain_cnt_q - 2'd1;
            end

            done_q <= (state_q == S_DRAIN) && (drain_cnt_q == 2'd0);
        end
    end

    // Per-slot evaluation of the row currently returned by the clause table.
    always_comb begin
        row_unsat = '0;
        for (int j = 0; j < SLOTS; j++) begin
            logic [CLAUSE_W-1:0] clause;
            clause = ct_row[ROW_W-1-CLAUSE_W*j -: CLAUSE_W];
            row_unsat[j] = (clause != '0) &&
                           !(lit_true(clause[23:16], assign_q) ||
                             lit_true(clause[15:8],  assign_q) ||
                             lit_true(clause[7:0],   assign_q));
        end
    end

    // Read-return tracking and stage 1: register the unsat bits with their row address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v_q    <= 1'b0;
            rd_addr_q <= '0;
            s1_v_q    <= 1'b0;
            s1_bits_q <= '0;
            s1_addr_q <= '0;
        end else begin
            rd_v_q    <= ct_read;
            rd_addr_q <= addr_q;
            s1_v_q    <= rd_v_q;
            s1_addr_q <= rd_addr_q;
            if (rd_v_q) begin
                s1_bits_q <= row_unsat;
            end
        end
    end

    // Stage 2: accumulate the count and capture the first unsatisfied clause once per scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= '0;
            first_addr_q <= '0;
            first_slot_q <= '0;
        end else if (start_ok) begin
            count_q      <= '0;
            first_addr_q <= '0;
            first_slot_q <= '0;
        end else if (s1_v_q) begin
            count_q <= count_q + 16'(popcount(s1_bits_q));
            if ((first_slot_q == 5'd0) && (s1_bits_q != '0)) begin
                first_addr_q <= s1_addr_q;
                first_slot_q <= lowest_slot(s1_bits_q);
            end
        end
    end

    assign ct_address  = addr_q;
    assign done        = done_q;
    assign unsat_count = count_q;
    assign any_unsat   = (count_q != 16'd0);
    assign first_addr  = first_addr_q;
    assign first_slot  = first_slot_q;

endmodule
